booth_div_sequencer: RTL and testbench
======================================

// Module: booth_div_sequencer
// PURPOSE
//  Iterative controller/datapath for the shared multiply/divide unit.
//  - Loads operands and runs N radix-2 iterations: Booth signed multiply, or non-restoring unsigned divide.
//  - Per iteration, generates the A+M / A-M / shift-select step and captures the combined {A,Q} register.
//  - Registers the final result with a start/ready/done handshake for the bus-side wrapper.
// PARAMETERS
//  N   4   operand width; product is 2N bits, quotient and remainder are N bits each
// PORTS
//  clk         in   1   system clock, rising edge
//  rst_n       in   1   synchronous, active-low reset
//  start       in   1   request; accepted only when ready=1
//  op          in   1   0=signed multiply, 1=unsigned divide
//  data_a      in   N   multiplicand / dividend
//  data_b      in   N   multiplier / divisor
//  ready       out  1   1 in IDLE only
//  busy        out  1   1 from LOAD through FIX
//  done        out  1   one-cycle pulse when results are valid
//  result_hi   out  N   mul: product[2N-1:N]; div: remainder
//  result_lo   out  N   mul: product[N-1:0];  div: quotient
//  div_zero    out  1   divide-by-zero flag, valid with done (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; ready=1; busy=0; done=0; result_hi/lo=0; div_zero=0; internal regs=0.
//  - FSM: IDLE -start-> LOAD -> RUN (N cycles, counter N-1..0) -> FIX -> DONE -> IDLE.
//  - start sampled at edge E0. LOAD is cycle 1, RUN is cycles 2..N+1, FIX is N+2, DONE is N+3.
//    done=1 in cycle N+3 only; this is cycle 7 for N=4.
//  - op and data_* are latched in LOAD and ignored after that. start while busy or in DONE is dropped.
//  - Internal A is N+1 bits, so a negative full-scale M cannot overflow. M register is N+1 bits:
//    multiply sign-extends it, divide zero-extends it.
//  - Multiply (LOAD: A=0, Q=data_a, Q_1=0, M=data_b). Each RUN cycle:
//    - {Q0,Q_1}=10 -> A=A-M; 01 -> A=A+M; else A unchanged.
//    - Then arithmetic shift right of {A,Q,Q_1} by 1.
//    - FIX: product={A[N-1:0],Q}.
//  - Divide (LOAD: A=0, Q=data_a, M=data_b). Each RUN cycle:
//    - {A,Q}<<=1.
//    - If the old A was >= 0 then A=A-M, else A=A+M.
//    - Q[0]=~A_new[N].
//    - FIX: if A<0 then A=A+M. Quotient=Q, remainder=A[N-1:0].
//  - result_hi/lo/div_zero are loaded on the FIX->DONE edge and held until the next LOAD.
//    During a new operation they keep the previous values.
//  - Back-to-back: start may be high in the IDLE cycle right after DONE. Minimum issue interval is N+4 cycles.
//  - Reset mid-operation (any state): IDLE on the next edge, all outputs to reset values, no done pulse.
// CONFIGURATION
//  DIV_BY_ZERO_EN defined:
//  - op=1 with data_b=0: LOAD goes directly to DONE, so done is in cycle 2.
//  - Outputs: div_zero=1, quotient={N{1'b1}}, remainder=data_a.
//  DIV_BY_ZERO_EN undefined:
//  - No short-circuit. The full N-iteration run yields the same quotient and remainder values, done in cycle N+3.
//  - div_zero is tied to 0.
// TESTING (N=4)
//  1 Reset: hold rst_n=0 for 2 cycles -> ready=1, busy=0, done=0, result_hi/lo=0.
//  2 Mul 3 x -2: data_a=4'h3, data_b=4'hE, op=0 -> done in cycle 7, {hi,lo}=8'hFA, div_zero=0.
//  3 Mul -8 x -8: data_a=data_b=4'h8 -> {hi,lo}=8'h40. Mul 7 x 7 -> 8'h31.
//  4 Div 13/3: data_a=4'hD, data_b=4'h3, op=1 -> lo=4'h4, hi=4'h1. Div 15/1 -> lo=4'hF, hi=0.
//  5 Div 9/0:
//    - With macro: done in cycle 2, div_zero=1, lo=4'hF, hi=4'h9.
//    - Without macro: done in cycle 7, div_zero=0, lo=4'hF, hi=4'h9.
//  6 Pulse start during RUN -> ignored, single done. Drop rst_n in RUN cycle 3 -> IDLE next edge, outputs 0, no done.

Source files
------------

// File: rtl/booth_div_sequencer_if.sv
// booth_div_sequencer_if
//   Handshake and operand/result bundle between the bus-side wrapper and the
//   shared multiply/divide sequencer.
//   Parameter N : operand width.
//   Signals     : start, op, data_a, data_b   (wrapper -> sequencer)
//                 ready, busy, done, result_hi, result_lo, div_zero
//                                             (sequencer -> wrapper)
//   Modports    : master = wrapper side, slave = sequencer side.
interface booth_div_sequencer_if #(
  parameter int N = 4
) ();
  logic         start;
  logic         op;
  logic [N-1:0] data_a;
  logic [N-1:0] data_b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] result_hi;
  logic [N-1:0] result_lo;
  logic         div_zero;

  modport master (
    output start, op, data_a, data_b,
    input  ready, busy, done, result_hi, result_lo, div_zero
  );

  modport slave (
    input  start, op, data_a, data_b,
    output ready, busy, done, result_hi, result_lo, div_zero
  );
endinterface

// File: rtl/booth_div_sequencer.sv
// booth_div_sequencer
//   Iterative datapath/controller for the shared multiply/divide unit.
//   op=0: Booth radix-2 signed multiply, product = {result_hi, result_lo}.
//   op=1: non-restoring unsigned divide, result_lo = quotient,
//         result_hi = remainder.
//   Sequence: IDLE -start-> LOAD -> RUN (N cycles) -> FIX -> DONE -> IDLE.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : synchronous active-low reset
//     bus   : booth_div_sequencer_if.slave (start/op/data_a/data_b in,
//             ready/busy/done/result_hi/result_lo/div_zero out)
//   Optional feature macro: DIV_BY_ZERO_EN
//     defined   : divide by zero skips RUN/FIX, done in cycle 2, div_zero=1
//     undefined : divide by zero runs the full sequence, div_zero tied to 0
module booth_div_sequencer #(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  booth_div_sequencer_if.slave  bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // A is one bit wider than the operands so -M of a full-scale negative
  // multiplicand and the divide partial remainder never overflow.
  logic [N:0]    a_q;
  logic [N-1:0]  q_q;
  logic          q_1_q;
  logic [N:0]    m_q;
  logic          op_q;
  logic [CW-1:0] count_q;

  logic [N-1:0]  result_hi_q;
  logic [N-1:0]  result_lo_q;

  // Single-iteration step results.
  logic [N:0]    a_sum;
  logic [N:0]    a_step;
  logic [N-1:0]  q_step;
  logic          q_1_step;
  logic [N:0]    a_sh;
  logic [N-1:0]  hi_fix;
  logic [N-1:0]  lo_fix;

`ifdef DIV_BY_ZERO_EN
  logic div_zero_q;
  logic div_zero_hit;
  assign div_zero_hit = bus.op && (bus.data_b == '0);
`endif

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // Next state and handshake outputs
  // ---------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    bus.ready = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) state_d = S_LOAD;
      end
      S_LOAD: begin
        bus.busy = 1'b1;
        state_d  = S_RUN;
`ifdef DIV_BY_ZERO_EN
        if (div_zero_hit) state_d = S_DONE;
`endif
      end
      S_RUN: begin
        bus.busy = 1'b1;
        if (count_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        bus.busy = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // One iteration step and final correction
  // ---------------------------------------------------------------------
  always_comb begin
    a_sum    = a_q;
    a_step   = a_q;
    q_step   = q_q;
    q_1_step = q_1_q;
    a_sh     = {a_q[N-1:0], q_q[N-1]};
    if (!op_q) begin
      // Booth: recode {Q0, Q_1}, then arithmetic shift {A, Q, Q_1} right.
      unique case ({q_q[0], q_1_q})
        2'b10:   a_sum = a_q - m_q;
        2'b01:   a_sum = a_q + m_q;
        default: a_sum = a_q;
      endcase
      a_step   = {a_sum[N], a_sum[N:1]};
      q_step   = {a_sum[0], q_q[N-1:1]};
      q_1_step = q_q[0];
    end else begin
      // Non-restoring: shift {A, Q} left, subtract or add by sign of old A,
      // new quotient bit is the inverted sign of the new A.
      a_step = a_q[N] ? (a_sh + m_q) : (a_sh - m_q);
      q_step = {q_q[N-2:0], ~a_step[N]};
    end
  end

  // Divide remainder correction is done modulo 2^N; only the low N bits
  // of A + M survive in the remainder anyway.
  assign hi_fix = op_q ? (a_q[N] ? (a_q[N-1:0] + m_q[N-1:0]) : a_q[N-1:0])
                       : a_q[N-1:0];
  assign lo_fix = q_q;

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q         <= '0;
      q_q         <= '0;
      q_1_q       <= 1'b0;
      m_q         <= '0;
      op_q        <= 1'b0;
      count_q     <= '0;
      result_hi_q <= '0;
      result_lo_q <= '0;
`ifdef DIV_BY_ZERO_EN
      div_zero_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_LOAD: begin
          op_q    <= bus.op;
          a_q     <= '0;
          q_q     <= bus.data_a;
          q_1_q   <= 1'b0;
          m_q     <= bus.op ? {1'b0, bus.data_b} : {bus.data_b[N-1], bus.data_b};
          count_q <= CW'(N - 1);
`ifdef DIV_BY_ZERO_EN
          if (div_zero_hit) begin
            result_hi_q <= bus.data_a;
            result_lo_q <= '1;
            div_zero_q  <= 1'b1;
          end
`endif
        end
        S_RUN: begin
          a_q     <= a_step;
          q_q     <= q_step;
          q_1_q   <= q_1_step;
          count_q <= count_q - 1'b1;
        end
        S_FIX: begin
          result_hi_q <= hi_fix;
          result_lo_q <= lo_fix;
`ifdef DIV_BY_ZERO_EN
          div_zero_q  <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.result_hi = result_hi_q;
  assign bus.result_lo = result_lo_q;
`ifdef DIV_BY_ZERO_EN
  assign bus.div_zero  = div_zero_q;
`else
  assign bus.div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_booth_div_sequencer.sv
// tb_booth_div_sequencer
//   Random and directed stimulus for booth_div_sequencer (N=4) checked
//   against a plain-arithmetic reference (signed product, unsigned / and %).
//   Honors DIV_BY_ZERO_EN the same way the design does.
module tb_booth_div_sequencer;

  localparam int N = 4;

  logic clk;
  logic rst_n;

  booth_div_sequencer_if #(.N(N)) bus ();

  booth_div_sequencer #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N-1:0] prev_hi = '0;
  logic [N-1:0] prev_lo = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: result and done cycle from arithmetic rules.
  task automatic model(input logic o, input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N-1:0] hi, output logic [N-1:0] lo,
                       output logic dz, output int lat);
    int pa, pb, p;
    logic [31:0] pv;
    dz  = 1'b0;
    lat = N + 3;
    if (!o) begin
      pa = $signed(a);
      pb = $signed(b);
      p  = pa * pb;
      pv = p;
      hi = pv[2*N-1:N];
      lo = pv[N-1:0];
    end else if (b == '0) begin
      hi = a;
      lo = '1;
`ifdef DIV_BY_ZERO_EN
      dz  = 1'b1;
      lat = 2;
`endif
    end else begin
      lo = N'(int'(a) / int'(b));
      hi = N'(int'(a) % int'(b));
    end
  endtask

  // Issue one operation on the next negedge and follow it to done.
  // glitch > 1 pulses start for one cycle during that cycle of the operation.
  task automatic run_op(input logic o, input logic [N-1:0] a, input logic [N-1:0] b,
                        input int glitch);
    logic [N-1:0] e_hi, e_lo;
    logic e_dz;
    int e_lat, got_lat, extra;
    model(o, a, b, e_hi, e_lo, e_dz, e_lat);
    @(negedge clk);
    check("ready_idle", bus.ready, 1);
    check("done_single", bus.done, 0);
    bus.start  = 1'b1;
    bus.op     = o;
    bus.data_a = a;
    bus.data_b = b;
    got_lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start = 1'b0;
        check("busy_load", bus.busy, 1);
      end
      if (k == 2) begin
        bus.op     = 1'($urandom);
        bus.data_a = N'($urandom);
        bus.data_b = N'($urandom);
        if (e_lat > 2) begin
          check("hold_hi", bus.result_hi, prev_hi);
          check("hold_lo", bus.result_lo, prev_lo);
        end
      end
      if (glitch > 1 && k == glitch) bus.start = 1'b1;
      if (glitch > 1 && k == glitch + 1) bus.start = 1'b0;
      if (bus.done) begin
        got_lat = k;
        break;
      end
    end
    if (got_lat < 0) begin
      check("done_timeout", 0, 1);
    end else begin
      check("latency", got_lat, e_lat);
      check("result_hi", bus.result_hi, e_hi);
      check("result_lo", bus.result_lo, e_lo);
      check("div_zero", bus.div_zero, e_dz);
    end
    prev_hi = e_hi;
    prev_lo = e_lo;
    if (glitch > 1) begin
      extra = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (bus.done) extra++;
      end
      check("glitch_no_extra_done", extra, 0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.op     = 1'b0;
    bus.data_a = '0;
    bus.data_b = '0;

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hi", bus.result_hi, 0);
    check("rst_lo", bus.result_lo, 0);
    check("rst_div_zero", bus.div_zero, 0);
    rst_n = 1'b1;

    // Directed cases, issued back-to-back.
    run_op(1'b0, 4'h3, 4'hE, 0);
    run_op(1'b0, 4'h8, 4'h8, 0);
    run_op(1'b0, 4'h7, 4'h7, 0);
    run_op(1'b1, 4'hD, 4'h3, 0);
    run_op(1'b1, 4'hF, 4'h1, 0);
    run_op(1'b1, 4'h9, 4'h0, 0);
    run_op(1'b1, 4'h0, 4'h7, 0);
    run_op(1'b0, 4'h8, 4'h7, 0);

    // Start pulse during RUN cycle 3 must be dropped.
    run_op(1'b0, 4'h5, 4'hB, 3);

    // Random mix, divisor zero roughly one time in eight.
    for (int i = 0; i < 60; i++) begin
      logic o;
      logic [N-1:0] a, b;
      o = 1'($urandom);
      a = N'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      run_op(o, a, b, 0);
    end

    // Reset in RUN cycle 3: IDLE next edge, outputs cleared, no done.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = 1'b0;
    bus.data_a = 4'h6;
    bus.data_b = 4'h5;
    begin
      int seen;
      seen = 0;
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        if (k == 1) bus.start = 1'b0;
        if (bus.done) seen++;
      end
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_ready", bus.ready, 1);
      check("midrst_busy", bus.busy, 0);
      check("midrst_done", bus.done, 0);
      check("midrst_hi", bus.result_hi, 0);
      check("midrst_lo", bus.result_lo, 0);
      check("midrst_div_zero", bus.div_zero, 0);
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (bus.done) seen++;
      end
      check("midrst_no_done", seen, 0);
    end
    prev_hi = '0;
    prev_lo = '0;

    // Recovers cleanly after the aborted operation.
    run_op(1'b1, 4'hE, 4'h4, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
